// File: rtl/uart_tx_cfg_if.sv
`default_nettype none
// uart_tx_cfg_if -- valid/ready word stream feeding the configurable UART transmitter (rev 1.0)
interface uart_tx_cfg_if #(
    parameter int MAX_DATA_BITS = 9
);
    logic                     valid;
    logic [MAX_DATA_BITS-1:0] data;
    logic                     ready;

    modport master (output valid, output data, input  ready);
    modport slave  (input  valid, input  data, output ready);
endinterface
`default_nettype wire

// File: rtl/uart_tx_cfg.sv
`default_nettype none
// uart_tx_cfg -- runtime-configurable UART TX with break generation and frame-done pulse (rev 1.0)
// Optional: define UART_TX_CTS_EN to add i_cts_n clear-to-send gating of o_ready.
module uart_tx_cfg #(
    parameter int MAX_DATA_BITS = 9,
    parameter int DIV_W         = 16
) (
    input  wire logic             i_clk,
    input  wire logic             i_rst,
    input  wire logic [DIV_W-1:0] i_cfg_div,
    input  wire logic [3:0]       i_cfg_nbits,
    input  wire logic [2:0]       i_cfg_par,
    input  wire logic [1:0]       i_cfg_stop,
`ifdef UART_TX_CTS_EN
    input  wire logic             i_cts_n,
`endif
    uart_tx_cfg_if.slave          stream,
    input  wire logic             i_break,
    output logic                  o_tx,
    output logic                  o_busy,
    output logic                  o_done
);
    localparam int              CW       = DIV_W + 1;
    localparam logic [CW-1:0]   C_ONE    = CW'(1);
    localparam logic [CW-1:0]   C_TWO    = CW'(2);
    localparam logic [3:0]      C_MIN_NB = 4'd5;
    localparam logic [3:0]      C_MAX_NB = 4'(MAX_DATA_BITS);

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_START    = 3'd1,
        S_DATA     = 3'd2,
        S_PARITY   = 3'd3,
        S_STOP     = 3'd4,
        S_BREAK    = 3'd5,
        S_BRK_MARK = 3'd6
    } state_e;

    state_e                   state_q, state_d;
    logic [CW-1:0]            cnt_q, cnt_d;
    logic [CW-1:0]            div_q, div_d;
    logic [3:0]               nbits_q, nbits_d;
    logic [3:0]               bit_q, bit_d;
    logic [2:0]               par_q, par_d;
    logic [1:0]               stop_q, stop_d;
    logic [MAX_DATA_BITS-1:0] shift_q, shift_d;
    logic                     acc_q, acc_d;

    logic                     w_cts_ok;
    logic                     w_ready;
    logic                     w_accept;
    logic [CW-1:0]            w_live_div;
    logic [3:0]               w_nbits;
    logic [2:0]               w_par;
    logic [CW-1:0]            w_stop_len;
    logic                     w_par_bit;
    logic                     w_period_end;

`ifdef UART_TX_CTS_EN
    assign w_cts_ok = !i_cts_n;
`else
    assign w_cts_ok = 1'b1;
`endif

    assign w_ready      = (state_q == S_IDLE) && !i_break && w_cts_ok && !i_rst;
    assign stream.ready = w_ready;
    assign w_accept     = stream.valid && w_ready;
    assign o_busy       = (state_q != S_IDLE);

    // Divisors below 2 would give a zero-length or one-cycle bit; force them to 2.
    assign w_live_div = (i_cfg_div < DIV_W'(2)) ? C_TWO : {1'b0, i_cfg_div};
    assign w_nbits    = (i_cfg_nbits < C_MIN_NB) ? C_MIN_NB :
                        (i_cfg_nbits > C_MAX_NB) ? C_MAX_NB : i_cfg_nbits;
    assign w_par      = (i_cfg_par > 3'd4) ? 3'd0 : i_cfg_par;

    assign w_period_end = (cnt_q == div_q - C_ONE);

    always_comb begin
        w_stop_len = div_q;
        case (stop_q)
            2'd0:    w_stop_len = div_q;
            2'd1:    w_stop_len = div_q + (div_q >> 1);
            default: w_stop_len = div_q << 1;
        endcase
    end

    always_comb begin
        w_par_bit = 1'b0;
        case (par_q)
            3'd1:    w_par_bit = acc_q;
            3'd2:    w_par_bit = ~acc_q;
            3'd3:    w_par_bit = 1'b1;
            default: w_par_bit = 1'b0;
        endcase
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q + C_ONE;
        div_d   = div_q;
        nbits_d = nbits_q;
        bit_d   = bit_q;
        par_d   = par_q;
        stop_d  = stop_q;
        shift_d = shift_q;
        acc_d   = acc_q;
        o_tx    = 1'b1;
        o_done  = 1'b0;
        case (state_q)
            S_IDLE: begin
                cnt_d = '0;
                if (i_break) begin
                    state_d = S_BREAK;
                end else if (w_accept) begin
                    shift_d = stream.data;
                    div_d   = w_live_div;
                    nbits_d = w_nbits;
                    par_d   = w_par;
                    stop_d  = i_cfg_stop;
                    state_d = S_START;
                end
            end
            S_START: begin
                o_tx = 1'b0;
                if (w_period_end) begin
                    cnt_d   = '0;
                    bit_d   = 4'd0;
                    acc_d   = 1'b0;
                    state_d = S_DATA;
                end
            end
            S_DATA: begin
                o_tx = shift_q[0];
                if (w_period_end) begin
                    cnt_d   = '0;
                    shift_d = shift_q >> 1;
                    acc_d   = acc_q ^ shift_q[0];
                    bit_d   = bit_q + 4'd1;
                    if (bit_q == nbits_q - 4'd1) begin
                        state_d = (par_q != 3'd0) ? S_PARITY : S_STOP;
                    end
                end
            end
            S_PARITY: begin
                o_tx = w_par_bit;
                if (w_period_end) begin
                    cnt_d   = '0;
                    state_d = S_STOP;
                end
            end
            S_STOP: begin
                if (cnt_q == w_stop_len - C_ONE) begin
                    o_done  = 1'b1;
                    cnt_d   = '0;
                    state_d = S_IDLE;
                end
            end
            S_BREAK: begin
                // Counter saturates so a long break cannot wrap; live divisor sets the minimum.
                o_tx = 1'b0;
                if (cnt_q >= w_live_div - C_ONE) begin
                    cnt_d = cnt_q;
                    if (!i_break) begin
                        cnt_d   = '0;
                        state_d = S_BRK_MARK;
                    end
                end
            end
            S_BRK_MARK: begin
                if (cnt_q >= (w_live_div << 1) - C_ONE) begin
                    cnt_d   = '0;
                    state_d = S_IDLE;
                end
            end
            default: begin
                cnt_d   = '0;
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            div_q   <= C_TWO;
            nbits_q <= C_MIN_NB;
            bit_q   <= 4'd0;
            par_q   <= 3'd0;
            stop_q  <= 2'd0;
            shift_q <= '0;
            acc_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            div_q   <= div_d;
            nbits_q <= nbits_d;
            bit_q   <= bit_d;
            par_q   <= par_d;
            stop_q  <= stop_d;
            shift_q <= shift_d;
            acc_q   <= acc_d;
        end
    end
endmodule
`default_nettype wire

// File: tb/tb_uart_tx_cfg.sv
`default_nettype none
// tb_uart_tx_cfg -- randomized and directed self-checking bench for uart_tx_cfg (rev 1.0)
module tb_uart_tx_cfg;
    logic        i_clk;
    logic        i_rst;
    logic [15:0] i_cfg_div;
    logic [3:0]  i_cfg_nbits;
    logic [2:0]  i_cfg_par;
    logic [1:0]  i_cfg_stop;
    logic        i_break;
    logic        i_cts_n;
    logic        o_tx;
    logic        o_busy;
    logic        o_done;

    int n_vec;
    int n_err;
    bit exp_q[$];

    uart_tx_cfg_if #(.MAX_DATA_BITS(9)) bus ();

    uart_tx_cfg #(.MAX_DATA_BITS(9), .DIV_W(16)) dut (
        .i_clk       (i_clk),
        .i_rst       (i_rst),
        .i_cfg_div   (i_cfg_div),
        .i_cfg_nbits (i_cfg_nbits),
        .i_cfg_par   (i_cfg_par),
        .i_cfg_stop  (i_cfg_stop),
`ifdef UART_TX_CTS_EN
        .i_cts_n     (i_cts_n),
`endif
        .stream      (bus),
        .i_break     (i_break),
        .o_tx        (o_tx),
        .o_busy      (o_busy),
        .o_done      (o_done)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    initial begin
        #3000000;
        $display("FAIL watchdog: got timeout, expected finish");
        $fatal(1);
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Line waveform of one frame, one entry per clock, built from the frame rules.
    task automatic model_frame(input int div_raw, input int nb_raw, input int par_raw,
                               input int stop_raw, input int data);
        int d, n, pm, ones, stop_cyc;
        bit v, pb;
        d  = (div_raw < 2) ? 2 : div_raw;
        n  = (nb_raw < 5) ? 5 : ((nb_raw > 9) ? 9 : nb_raw);
        pm = (par_raw > 4) ? 0 : par_raw;
        exp_q.delete();
        repeat (d) exp_q.push_back(1'b0);
        ones = 0;
        for (int b = 0; b < n; b++) begin
            v = 1'(((data >> b) & 1));
            ones += int'(v);
            repeat (d) exp_q.push_back(v);
        end
        if (pm != 0) begin
            if (pm == 1)      pb = 1'((ones % 2));
            else if (pm == 2) pb = !1'((ones % 2));
            else              pb = (pm == 3);
            repeat (d) exp_q.push_back(pb);
        end
        stop_cyc = (stop_raw == 0) ? d : ((stop_raw == 1) ? (d * 3) / 2 : 2 * d);
        repeat (stop_cyc) exp_q.push_back(1'b1);
    endtask

    task automatic send_frame(input int dv, input int nb, input int pr, input int st,
                              input int dat, input bit hold, input bit expect_now);
        int w;
        i_cfg_div   = 16'(dv);
        i_cfg_nbits = 4'(nb);
        i_cfg_par   = 3'(pr);
        i_cfg_stop  = 2'(st);
        bus.data    = 9'(dat);
        bus.valid   = 1'b1;
        i_cts_n     = 1'b0;
        model_frame(dv, nb, pr, st, dat);
        w = 0;
        @(negedge i_clk);
        while (!bus.ready && w < 200) begin
            w++;
            @(negedge i_clk);
        end
        if (expect_now) check_eq("b2b_gap", w, 0);
        check_eq("ready_wait", {31'd0, bus.ready}, 1);
        @(posedge i_clk);
        #1;
        if (!hold) bus.valid = 1'b0;
        for (int i = 0; i < exp_q.size(); i++) begin
            if (i > 0) begin
                @(posedge i_clk);
                #1;
            end
            if (i == exp_q.size() / 2) begin
                i_cfg_div   = 16'($urandom_range(0, 20));
                i_cfg_nbits = 4'($urandom);
                i_cfg_par   = 3'($urandom);
                i_cfg_stop  = 2'($urandom);
                bus.data    = 9'($urandom);
                i_cts_n     = 1'($urandom);
            end
            check_eq("tx", {31'd0, o_tx}, {31'd0, exp_q[i]});
            check_eq("busy", {31'd0, o_busy}, 1);
            check_eq("done", {31'd0, o_done}, (i == exp_q.size() - 1) ? 1 : 0);
        end
        @(posedge i_clk);
        #1;
        check_eq("idle_tx", {31'd0, o_tx}, 1);
        check_eq("idle_busy", {31'd0, o_busy}, 0);
        check_eq("idle_done", {31'd0, o_done}, 0);
        i_cts_n = 1'b0;
    endtask

    task automatic do_break(input int dv, input int len);
        int d, lo;
        d  = (dv < 2) ? 2 : dv;
        lo = (len > d) ? len : d;
        i_cfg_div = 16'(dv);
        i_break   = 1'b1;
        bus.valid = 1'b1;
        @(negedge i_clk);
        check_eq("brk_ready", {31'd0, bus.ready}, 0);
        for (int i = 0; i < lo + 2 * d; i++) begin
            @(posedge i_clk);
            #1;
            if (i == len - 1) i_break = 1'b0;
            if (i == lo) bus.valid = 1'b0;
            check_eq("brk_tx", {31'd0, o_tx}, (i < lo) ? 0 : 1);
            check_eq("brk_busy", {31'd0, o_busy}, 1);
            check_eq("brk_done", {31'd0, o_done}, 0);
        end
        @(posedge i_clk);
        #1;
        check_eq("brk_end_busy", {31'd0, o_busy}, 0);
        check_eq("brk_end_tx", {31'd0, o_tx}, 1);
        @(negedge i_clk);
        check_eq("brk_end_ready", {31'd0, bus.ready}, 1);
    endtask

    initial begin
        n_vec       = 0;
        n_err       = 0;
        i_rst       = 1'b1;
        i_break     = 1'b0;
        i_cts_n     = 1'b0;
        bus.valid   = 1'b0;
        bus.data    = '0;
        i_cfg_div   = 16'd4;
        i_cfg_nbits = 4'd8;
        i_cfg_par   = 3'd0;
        i_cfg_stop  = 2'd0;
        repeat (3) @(posedge i_clk);
        #1;
        check_eq("rst_tx", {31'd0, o_tx}, 1);
        check_eq("rst_busy", {31'd0, o_busy}, 0);
        check_eq("rst_done", {31'd0, o_done}, 0);
        check_eq("rst_ready", {31'd0, bus.ready}, 0);
        i_rst = 1'b0;
        @(negedge i_clk);
        check_eq("post_rst_ready", {31'd0, bus.ready}, 1);

        send_frame(4, 8, 0, 0, 'hA5, 1'b0, 1'b0);
        send_frame(3, 7, 1, 2, 'h53, 1'b0, 1'b0);
        send_frame(3, 7, 2, 0, 'h53, 1'b0, 1'b0);
        send_frame(5, 5, 3, 1, 'h1FF, 1'b0, 1'b0);
        send_frame(4, 8, 0, 0, $urandom, 1'b1, 1'b0);
        send_frame(8, 8, 0, 0, $urandom, 1'b0, 1'b1);
        do_break(6, 2);

        // Reset while in DATA aborts the frame immediately.
        i_cfg_div   = 16'd4;
        i_cfg_nbits = 4'd8;
        i_cfg_par   = 3'd0;
        i_cfg_stop  = 2'd0;
        bus.valid   = 1'b1;
        @(negedge i_clk);
        @(posedge i_clk);
        #1;
        bus.valid = 1'b0;
        repeat (10) @(posedge i_clk);
        #1;
        check_eq("mid_busy", {31'd0, o_busy}, 1);
        i_rst = 1'b1;
        @(negedge i_clk);
        check_eq("mid_rst_ready", {31'd0, bus.ready}, 0);
        @(posedge i_clk);
        #1;
        check_eq("mid_rst_tx", {31'd0, o_tx}, 1);
        check_eq("mid_rst_busy", {31'd0, o_busy}, 0);
        i_rst = 1'b0;
        @(negedge i_clk);
        check_eq("mid_rst_ready2", {31'd0, bus.ready}, 1);

`ifdef UART_TX_CTS_EN
        i_cts_n   = 1'b1;
        bus.valid = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge i_clk);
            check_eq("cts_ready", {31'd0, bus.ready}, 0);
            check_eq("cts_tx", {31'd0, o_tx}, 1);
            check_eq("cts_busy", {31'd0, o_busy}, 0);
        end
        send_frame(4, 8, 1, 0, $urandom, 1'b0, 1'b1);
`endif

        for (int k = 0; k < 30; k++) begin
            if ($urandom_range(0, 4) == 0) begin
                do_break($urandom_range(0, 5), $urandom_range(1, 10));
            end else begin
                send_frame($urandom_range(0, 7), $urandom_range(0, 15), $urandom_range(0, 7),
                           $urandom_range(0, 3), $urandom, 1'b0, 1'b0);
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/uart_tx_cfg.md
Name: uart_tx_cfg

Overview:
Runtime-configurable UART transmitter, the parametrised successor to the fixed-format TX. Frame format (baud divisor, data bits, parity mode, stop bits) is programmed through config inputs, not compile-time parameters. Takes bytes over a valid/ready stream instead of a FIFO read strobe, and adds break generation and frame-done signalling. Sits between the TX FIFO/packetiser and the board TX pin.

Parameters:
MAX_DATA_BITS, 9, width of i_data; legal i_cfg_nbits range is 5..MAX_DATA_BITS
DIV_W, 16, width of baud divisor input

Ports:
i_clk  in  1  system clock
i_rst  in  1  synchronous active-high reset
i_cfg_div  in  DIV_W  clocks per bit; values 0/1 are treated as 2
i_cfg_nbits  in  4  data bits per frame, 5..MAX_DATA_BITS; out-of-range values clamp (<5 gives 5, >MAX gives MAX)
i_cfg_par  in  3  parity: 0 none, 1 even, 2 odd, 3 mark (1), 4 space (0), 5-7 treated as none
i_cfg_stop  in  2  stop bits: 0 gives 1, 1 gives 1.5, 2 or 3 give 2
i_valid  in  1  data word valid
i_data  in  MAX_DATA_BITS  word; LSB sent first; bits at and above nbits are ignored
o_ready  out  1  block can accept a word this cycle
i_break  in  1  break request (level)
o_tx  out  1  serial line, idle high
o_busy  out  1  high in every state except IDLE
o_done  out  1  one-cycle pulse on the last cycle of a frame's final stop bit

Behaviour:
- Reset (i_rst sampled high on a clock edge): o_tx=1, o_ready=0 for that cycle, then IDLE. o_busy=0, o_done=0. All counters cleared. Reset mid-frame aborts the frame, and o_tx is 1 from the next edge.
- States: IDLE, START, DATA, PARITY, STOP, BREAK, BRK_MARK.
- o_ready = (state==IDLE) && !i_break. Handshake: a word is accepted on a cycle with i_valid && o_ready.
- On accept, latch i_data and all cfg inputs into shadow registers. Cfg changes mid-frame have no effect. Go to START.
- Latency: o_tx falls on the first edge after the accept cycle.
- Bit period: counter 0..div-1, each bit lasts exactly div cycles.
- START: 1 period at 0, then DATA.
- DATA: nbits periods, shift register LSB first. Then PARITY if par!=none, else STOP.
- PARITY value: even gives XOR of the nbits data bits; odd gives its inverse; mark gives 1; space gives 0. Only the first nbits bits take part.
- STOP: o_tx=1 for div, floor(div*3/2), or 2*div cycles for 1, 1.5, or 2 stop bits. o_done pulses on the final cycle. Next state is IDLE.
- Total frame length = div*(1+nbits+parity+stop_bits) cycles, with the 1.5-stop floor rule.
- Back-to-back: if i_valid is held, the next accept happens in the IDLE cycle after STOP. This gives exactly one idle-high cycle between frames.
- Break: in IDLE with i_break=1, go to BREAK (i_break has priority over i_valid) and drive o_tx=0.
  - Stay in BREAK while i_break=1, with a minimum of 1 bit period (div cycles, using the live i_cfg_div).
  - Then go to BRK_MARK: o_tx=1 for 2 bit periods, then IDLE.
  - i_break asserted mid-frame is ignored until the frame returns to IDLE.
- Counter widths: bit counter is DIV_W+1 bits, so 2*div cannot overflow. No wrap is allowed within a period.

Optional Feature:
UART_TX_CTS_EN
- Defined: adds input i_cts_n (1 bit, active-low clear-to-send, already synchronised).
  - o_ready additionally requires i_cts_n==0.
  - A frame in progress always completes regardless of CTS.
  - Break is not gated by CTS.
- Not defined: no port, and o_ready is as specified above.

Test Plan:
- 8N1 frame: div=4, nbits=8, par=0, stop=0, send 0xA5. Line sees 0,1,0,1,0,0,1,0,1,1, each bit 4 cycles. o_done at cycle 40 after accept. o_busy is high for 40 cycles.
- 7E2 and 7O1 frames: div=3, send 0x53 (7 data bits, four ones). Even parity bit = 0, odd parity bit = 1. 2-stop frame lasts 33 cycles, 1-stop frame lasts 30 cycles.
- 5-bit frame with 1.5 stop, mark parity: div=5, nbits=5, par=3, stop=1, send 0x1FF. Only 0x1F is transmitted. Parity bit = 1. Stop lasts 7 cycles; frame lasts 42 cycles.
- Cfg change mid-frame: start a frame at div=4, change to div=8 during DATA. Current frame keeps div=4. Next frame uses div=8. Back-to-back valid leaves exactly 1 idle cycle between frames.
- Break, then reset: pulse i_break for 2 cycles with div=6. o_tx is low for 6 cycles, high for 12 cycles, then o_ready=1. Separately, assert i_rst in DATA: o_tx=1 and o_busy=0 on the next edge.
- With UART_TX_CTS_EN: hold i_cts_n=1 with i_valid=1. o_ready stays 0 and nothing is sent. Deassert CTS, and a frame starts within 1 cycle. Raise CTS mid-frame, and the frame still completes.
